// File: rtl/reg_src_select_pipe.sv
// Pipelined register-source selector: picks Input1, Input2 or a writable constant into one registered stage.
// Optional write-to-read forwarding of table writes is enabled by defining REG_SRC_SELECT_CONST_BYPASS_EN.
module reg_src_select_pipe #(
   parameter int unsigned WIDTH     = 17,
   parameter int unsigned NUM_CONST = 3,
   parameter int unsigned SEL_W     = 3,
   parameter int unsigned RESET_C0  = 2,
   parameter int unsigned RESET_C1  = 4,
   parameter int unsigned RESET_C2  = 15,
   localparam int unsigned ADDR_W   = (NUM_CONST > 1) ? $clog2(NUM_CONST) : 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [WIDTH-1:0]  Input1,
   input  logic [WIDTH-1:0]  Input2,
   input  logic [SEL_W-1:0]  Selection,
   input  logic              InValid,
   output logic              InReady,
   output logic [WIDTH-1:0]  Output,
   output logic              OutValid,
   input  logic              OutReady,
   input  logic              ConstWrEn,
   input  logic [ADDR_W-1:0] ConstWrAddr,
   input  logic [WIDTH-1:0]  ConstWrData,
   output logic              IllegalSel,
   input  logic              ErrClear
);

   function automatic logic [WIDTH-1:0] reset_entry(input int unsigned idx);
      case (idx)
         0:       return WIDTH'(RESET_C0);
         1:       return WIDTH'(RESET_C1);
         2:       return WIDTH'(RESET_C2);
         default: return '0;
      endcase
   endfunction

   logic [WIDTH-1:0] table_q [NUM_CONST];
   logic [WIDTH-1:0] table_d [NUM_CONST];
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             illegal_q, illegal_d;
   logic [WIDTH-1:0] sel_val_c;
   logic             illegal_c;
   logic             accept_c;

   assign InReady  = !out_valid_q || OutReady;
   assign accept_c = InValid && InReady;

   // Source decode; out-of-range table addresses simply match no entry
   always_comb begin
      sel_val_c = '0;
      illegal_c = 32'(Selection) > (NUM_CONST + 1);
      if (Selection == '0) begin
         sel_val_c = Input1;
      end else if (Selection == SEL_W'(NUM_CONST + 1)) begin
         sel_val_c = Input2;
      end
      for (int unsigned i = 0; i < NUM_CONST; i++) begin
         if (Selection == SEL_W'(i + 1)) begin
`ifdef REG_SRC_SELECT_CONST_BYPASS_EN
            if (ConstWrEn && (ConstWrAddr == ADDR_W'(i))) begin
               sel_val_c = ConstWrData;
            end else begin
               sel_val_c = table_q[i];
            end
`else
            sel_val_c = table_q[i];
`endif
         end
      end
   end

   always_comb begin
      table_d = table_q;
      for (int unsigned i = 0; i < NUM_CONST; i++) begin
         if (ConstWrEn && (ConstWrAddr == ADDR_W'(i))) begin
            table_d[i] = ConstWrData;
         end
      end
   end

   // Output stage and sticky error; a set in the same cycle as a clear wins
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      illegal_d   = illegal_q;
      if (accept_c) begin
         out_d       = sel_val_c;
         out_valid_d = 1'b1;
      end else if (OutReady) begin
         out_valid_d = 1'b0;
      end
      if (accept_c && illegal_c) begin
         illegal_d = 1'b1;
      end else if (ErrClear) begin
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_CONST; i++) begin
            table_q[i] <= reset_entry(i);
         end
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
         table_q     <= table_d;
      end
   end

   assign Output     = out_q;
   assign OutValid   = out_valid_q;
   assign IllegalSel = illegal_q;

endmodule
